// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: shares one OBI-style memory port between an instruction
// burst-read port and a data read/write port. At most one downstream
// transaction is in flight at a time.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   imem_req_i/addr_i -> gnt/rvalid/rdata   instruction burst reads
//   dmem_req/we/be/addr/wdata -> gnt/rvalid/rdata   data reads and writes
//   mem_req/we/be/addr/wdata, mem_gnt/rvalid/rdata  downstream memory port
//   busy_o, timeout_o, spurious_o     status and one-cycle error pulses
module obi_mem_arbiter #(
  parameter int unsigned IBURST_LEN = 8,
  parameter int unsigned WRITE_RSP  = 0,
  parameter int unsigned TIMEOUT    = 1024,
  localparam int unsigned AW = 64,
  localparam int unsigned DW = 64,
  localparam int unsigned BW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          imem_req_i,
  input  logic [AW-1:0] imem_addr_i,
  output logic          imem_gnt_o,
  output logic          imem_rvalid_o,
  output logic [DW-1:0] imem_rdata_o,
  input  logic          dmem_req_i,
  input  logic          dmem_we_i,
  input  logic [BW-1:0] dmem_be_i,
  input  logic [AW-1:0] dmem_addr_i,
  input  logic [DW-1:0] dmem_wdata_i,
  output logic          dmem_gnt_o,
  output logic          dmem_rvalid_o,
  output logic [DW-1:0] dmem_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [BW-1:0] mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o,
  output logic          timeout_o,
  output logic          spurious_o
);

  localparam int unsigned BEAT_W = 8;
  localparam int unsigned WAIT_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_IRESP = 2'd2;
  localparam logic [1:0] S_DRESP = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(IBURST_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              dwrite_q, dwrite_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  // State and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_D;
      dwrite_q     <= 1'b0;
      beat_q       <= '0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      dwrite_q     <= dwrite_d;
      beat_q       <= beat_d;
      wait_q       <= wait_d;
    end
  end

  // Next state, arbitration and downstream/upstream handshakes
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    dwrite_d      = dwrite_q;
    beat_d        = beat_q;
    wait_d        = wait_q;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_be_o      = '0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    imem_gnt_o    = 1'b0;
    dmem_gnt_o    = 1'b0;
    imem_rvalid_o = 1'b0;
    dmem_rvalid_o = 1'b0;
    timeout_o     = 1'b0;
    spurious_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        spurious_o = mem_rvalid_i;
        beat_d     = '0;
        wait_d     = '0;
        if (imem_req_i || dmem_req_i) begin
          state_d = S_ADDR;
          // On a tie the previous owner yields
          if (imem_req_i && dmem_req_i) begin
            owner_d = (last_owner_q == OWN_D) ? OWN_I : OWN_D;
          end else begin
            owner_d = imem_req_i ? OWN_I : OWN_D;
          end
        end
      end

      S_ADDR: begin
        spurious_o = mem_rvalid_i;
        mem_req_o  = 1'b1;
        beat_d     = '0;
        wait_d     = '0;
        if (owner_q == OWN_I) begin
          mem_be_o   = '1;
          mem_addr_o = imem_addr_i;
        end else begin
          mem_we_o    = dmem_we_i;
          mem_be_o    = dmem_be_i;
          mem_addr_o  = dmem_addr_i;
          mem_wdata_o = dmem_wdata_i;
        end
        if (mem_gnt_i) begin
          last_owner_d = owner_q;
          if (owner_q == OWN_I) begin
            imem_gnt_o = 1'b1;
            state_d    = S_IRESP;
          end else begin
            dmem_gnt_o = 1'b1;
            dwrite_d   = dmem_we_i;
            // Posted writes finish at grant; otherwise wait for the response
            state_d    = (dmem_we_i && (WRITE_RSP == 0)) ? S_IDLE : S_DRESP;
          end
        end
      end

      S_IRESP, S_DRESP: begin
        if (mem_rvalid_i) begin
          wait_d = '0;
          if (state_q == S_IRESP) begin
            imem_rvalid_o = 1'b1;
            if (beat_q == BEAT_LAST) begin
              state_d = S_IDLE;
            end else begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end else begin
            // Write completions are consumed here, not forwarded
            dmem_rvalid_o = ~dwrite_q;
            state_d       = S_IDLE;
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout_o = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs stay quiet while reset is held, whatever the stale state says
    if (rst_i) begin
      mem_req_o     = 1'b0;
      mem_we_o      = 1'b0;
      mem_be_o      = '0;
      mem_addr_o    = '0;
      mem_wdata_o   = '0;
      imem_gnt_o    = 1'b0;
      dmem_gnt_o    = 1'b0;
      imem_rvalid_o = 1'b0;
      dmem_rvalid_o = 1'b0;
      timeout_o     = 1'b0;
      spurious_o    = 1'b0;
    end
  end

  assign busy_o       = (state_q != S_IDLE) && !rst_i;
  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter: drives obi_mem_arbiter with randomized requests, grant
// delays and response gaps, and checks it against expectations computed from
// the arbitration, burst-length and timeout rules.
module tb_obi_mem_arbiter;
  localparam int unsigned IBURST = 8;
  localparam int unsigned TMO    = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_i;
  logic [63:0] imem_addr_i;
  logic        imem_gnt_o, imem_rvalid_o;
  logic [63:0] imem_rdata_o;
  logic        dmem_req_i, dmem_we_i;
  logic [7:0]  dmem_be_i;
  logic [63:0] dmem_addr_i, dmem_wdata_i;
  logic        dmem_gnt_o, dmem_rvalid_o;
  logic [63:0] dmem_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        busy_o, timeout_o, spurious_o;

  always #5 clk_i = ~clk_i;

  obi_mem_arbiter #(.IBURST_LEN(IBURST), .WRITE_RSP(0), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_gnt_o(imem_gnt_o),
    .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
    .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i), .dmem_be_i(dmem_be_i),
    .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i), .dmem_gnt_o(dmem_gnt_o),
    .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .timeout_o(timeout_o), .spurious_o(spurious_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: 1 when the data port owned the last granted transaction
  bit ref_last_d;

  int          o_idle_mreq, o_mreq_cycles, o_igrant, o_dgrant;
  logic        o_we;
  logic [7:0]  o_be;
  logic [63:0] o_addr, o_wdata;
  int          o_ircnt, o_drcnt, o_spur, o_to;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  function automatic bit pick_data(bit ir, bit dr, bit last_d);
    if (ir && dr) return !last_d;
    return dr;
  endfunction

  function automatic bit data_queue_bad();
    if (obs_q.size() != exp_q.size()) return 1'b1;
    foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_i = 1'b0; dmem_req_i = 1'b0; dmem_we_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  task automatic rand_fields();
    imem_addr_i  = {$urandom(), $urandom()};
    dmem_addr_i  = {$urandom(), $urandom()};
    dmem_wdata_i = {$urandom(), $urandom()};
    dmem_be_i    = 8'($urandom());
    mem_rdata_i  = {$urandom(), $urandom()};
  endtask

  // One IDLE cycle presenting requests, then ADDR for gdelay+1 cycles
  task automatic req_and_grant(input bit ir, input bit dr, input bit we, input int gdelay);
    imem_req_i = ir; dmem_req_i = dr; dmem_we_i = we;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    o_mreq_cycles = 0; o_igrant = 0; o_dgrant = 0;
    @(negedge clk_i);
    o_idle_mreq = int'(mem_req_o);
    next_cycle();
    for (int k = 0; k <= gdelay; k++) begin
      mem_gnt_i = (k == gdelay);
      @(negedge clk_i);
      o_mreq_cycles += int'(mem_req_o);
      o_igrant += int'(imem_gnt_o);
      o_dgrant += int'(dmem_gnt_o);
      if (k == gdelay) begin
        o_we = mem_we_o; o_be = mem_be_o; o_addr = mem_addr_o; o_wdata = mem_wdata_o;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  // Memory returns nbeats responses, each after 0..maxgap idle cycles
  task automatic respond(input int nbeats, input int maxgap);
    o_ircnt = 0; o_drcnt = 0; o_spur = 0; o_to = 0;
    exp_q.delete(); obs_q.delete();
    for (int b = 0; b < nbeats; b++) begin
      int gap;
      gap = int'($urandom_range(maxgap, 0));
      for (int g = 0; g <= gap; g++) begin
        mem_rvalid_i = (g == gap);
        mem_rdata_i  = {$urandom(), $urandom()};
        if (g == gap) exp_q.push_back(mem_rdata_i);
        @(negedge clk_i);
        o_ircnt += int'(imem_rvalid_o);
        o_drcnt += int'(dmem_rvalid_o);
        if (imem_rvalid_o) obs_q.push_back(imem_rdata_o);
        if (dmem_rvalid_o) obs_q.push_back(dmem_rdata_o);
        o_spur += int'(spurious_o);
        o_to   += int'(timeout_o);
        next_cycle();
      end
    end
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] quiet;
    rst_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_fields();
      imem_req_i = 1'b1; dmem_req_i = 1'b1; dmem_we_i = 1'b1;
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
      next_cycle();
      @(negedge clk_i);
      quiet = {busy_o, imem_gnt_o, dmem_gnt_o, imem_rvalid_o, dmem_rvalid_o,
               mem_req_o, mem_we_o, timeout_o, spurious_o, |mem_be_o, |mem_addr_o};
      checks++;
      if (quiet !== 11'd0) begin
        errors++; $display("FAIL reset_outputs: got %b expected %b", quiet, 11'd0);
      end
      checks++;
      if (imem_rdata_o !== mem_rdata_i || dmem_rdata_o !== mem_rdata_i) begin
        errors++; $display("FAIL reset_rdata_passthru: got %h/%h expected %h", imem_rdata_o, dmem_rdata_o, mem_rdata_i);
      end
    end
    next_cycle();
    rst_i = 1'b0; idle_inputs(); ref_last_d = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({busy_o, mem_req_o} !== 2'b00) begin
      errors++; $display("FAIL reset_idle: got busy/req %b expected 00", {busy_o, mem_req_o});
    end
    next_cycle();
  endtask

  task automatic test_ifetch();
    rand_fields();
    imem_addr_i = 64'h100;
    req_and_grant(1'b1, 1'b0, 1'b0, 0);
    checks++;
    if (o_idle_mreq !== 0 || o_mreq_cycles !== 1) begin
      errors++; $display("FAIL ifetch_latency: got idle_req %0d addr_cycles %0d expected 0 1", o_idle_mreq, o_mreq_cycles);
    end
    checks++;
    if (o_igrant !== 1 || o_dgrant !== 0) begin
      errors++; $display("FAIL ifetch_grant: got igrant %0d dgrant %0d expected 1 0", o_igrant, o_dgrant);
    end
    checks++;
    if (o_addr !== 64'h100 || o_we !== 1'b0 || o_be !== 8'hFF || o_wdata !== 64'd0) begin
      errors++; $display("FAIL ifetch_fields: got addr %h we %b be %h wdata %h expected 100 0 ff 0", o_addr, o_we, o_be, o_wdata);
    end
    ref_last_d = 1'b0;
    respond(IBURST, 3);
    checks++;
    if (o_ircnt !== IBURST || o_drcnt !== 0) begin
      errors++; $display("FAIL ifetch_beats: got i %0d d %0d expected %0d 0", o_ircnt, o_drcnt, IBURST);
    end
    checks++;
    if (data_queue_bad()) begin
      errors++; $display("FAIL ifetch_data: got %0d beats expected %0d matching beats", obs_q.size(), exp_q.size());
    end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL ifetch_busy_after: got %b expected 0", busy_o);
    end
    next_cycle();
  endtask

  task automatic test_arbitration();
    bit exp_d;
    rst_i = 1'b1; idle_inputs();
    next_cycle(); next_cycle();
    rst_i = 1'b0; ref_last_d = 1'b1;
    for (int p = 0; p < 3; p++) begin
      exp_d = pick_data(1'b1, 1'b1, ref_last_d);
      rand_fields();
      req_and_grant(1'b1, 1'b1, 1'b0, int'($urandom_range(2, 0)));
      checks++;
      if (o_igrant !== int'(!exp_d) || o_dgrant !== int'(exp_d)) begin
        errors++; $display("FAIL arb_pair%0d: got igrant %0d dgrant %0d expected data_wins=%0d", p, o_igrant, o_dgrant, exp_d);
      end
      ref_last_d = exp_d;
      respond(exp_d ? 1 : IBURST, 2);
      checks++;
      if (o_ircnt !== (exp_d ? 0 : IBURST) || o_drcnt !== (exp_d ? 1 : 0)) begin
        errors++; $display("FAIL arb_beats%0d: got i %0d d %0d expected data_wins=%0d", p, o_ircnt, o_drcnt, exp_d);
      end
    end
  endtask

  task automatic test_write();
    rand_fields();
    dmem_addr_i = 64'h10000; dmem_be_i = 8'h0F;
    req_and_grant(1'b0, 1'b1, 1'b1, 0);
    checks++;
    if (o_we !== 1'b1 || o_be !== 8'h0F || o_addr !== 64'h10000 || o_wdata !== dmem_wdata_i) begin
      errors++; $display("FAIL write_fields: got we %b be %h addr %h wdata %h expected 1 0f 10000 %h", o_we, o_be, o_addr, o_wdata, dmem_wdata_i);
    end
    checks++;
    if (o_dgrant !== 1 || o_igrant !== 0) begin
      errors++; $display("FAIL write_grant: got dgrant %0d igrant %0d expected 1 0", o_dgrant, o_igrant);
    end
    ref_last_d = 1'b1;
    // A late response after a posted write lands in IDLE and is flagged
    mem_rvalid_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({busy_o, dmem_rvalid_o, spurious_o} !== 3'b001) begin
      errors++; $display("FAIL write_idle_next: got busy/drvalid/spur %b expected 001", {busy_o, dmem_rvalid_o, spurious_o});
    end
    next_cycle();
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_timeout();
    int first, cnt, drv;
    logic busy_at;
    first = 0; cnt = 0; drv = 0; busy_at = 1'bx;
    rand_fields();
    req_and_grant(1'b0, 1'b1, 1'b0, 0);
    ref_last_d = 1'b1;
    for (int k = 1; k <= int'(TMO) + 4; k++) begin
      @(negedge clk_i);
      if (timeout_o) begin
        if (first == 0) first = k;
        cnt++;
      end
      drv += int'(dmem_rvalid_o);
      if (k == int'(TMO) + 1) busy_at = busy_o;
      next_cycle();
    end
    checks++;
    if (first !== int'(TMO) || cnt !== 1) begin
      errors++; $display("FAIL timeout_pulse: got cycle %0d count %0d expected %0d 1", first, cnt, TMO);
    end
    checks++;
    if (busy_at !== 1'b0 || drv !== 0) begin
      errors++; $display("FAIL timeout_after: got busy %b drvalid %0d expected 0 0", busy_at, drv);
    end
  endtask

  task automatic test_spurious();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = {$urandom(), $urandom()};
    @(negedge clk_i);
    checks++;
    if ({spurious_o, imem_rvalid_o, dmem_rvalid_o, busy_o} !== 4'b1000) begin
      errors++; $display("FAIL spurious_idle: got spur/irv/drv/busy %b expected 1000", {spurious_o, imem_rvalid_o, dmem_rvalid_o, busy_o});
    end
    next_cycle();
    mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (spurious_o !== 1'b0) begin
      errors++; $display("FAIL spurious_one_cycle: got %b expected 0", spurious_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_midburst();
    rand_fields();
    req_and_grant(1'b1, 1'b0, 1'b0, int'($urandom_range(2, 0)));
    respond(3, 2);
    checks++;
    if (o_ircnt !== 3) begin
      errors++; $display("FAIL midburst_pre: got %0d beats expected 3", o_ircnt);
    end
    rst_i = 1'b1; mem_rvalid_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({busy_o, imem_rvalid_o, spurious_o} !== 3'b000) begin
      errors++; $display("FAIL midburst_in_reset: got busy/irv/spur %b expected 000", {busy_o, imem_rvalid_o, spurious_o});
    end
    next_cycle();
    rst_i = 1'b0; ref_last_d = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({busy_o, imem_rvalid_o, spurious_o} !== 3'b001) begin
      errors++; $display("FAIL midburst_after_reset: got busy/irv/spur %b expected 001", {busy_o, imem_rvalid_o, spurious_o});
    end
    next_cycle();
    mem_rvalid_i = 1'b0;
    rand_fields();
    req_and_grant(1'b0, 1'b1, 1'b0, 1);
    checks++;
    if (o_dgrant !== 1 || o_igrant !== 0) begin
      errors++; $display("FAIL midburst_dread_grant: got dgrant %0d igrant %0d expected 1 0", o_dgrant, o_igrant);
    end
    respond(1, 3);
    checks++;
    if (o_drcnt !== 1 || o_ircnt !== 0 || data_queue_bad()) begin
      errors++; $display("FAIL midburst_dread_resp: got d %0d i %0d expected 1 0 with matching data", o_drcnt, o_ircnt);
    end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL midburst_dread_busy: got %b expected 0", busy_o);
    end
    next_cycle();
  endtask

  task automatic test_random();
    bit ir, dr, we, exp_d;
    int gd, exp_i_beats, exp_d_beats;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_be;
    logic        e_we;
    for (int t = 0; t < 20; t++) begin
      ir = 1'($urandom()); dr = 1'($urandom()); we = 1'($urandom());
      if (!ir && !dr) dr = 1'b1;
      gd = int'($urandom_range(3, 0));
      rand_fields();
      exp_d   = pick_data(ir, dr, ref_last_d);
      e_addr  = exp_d ? dmem_addr_i : imem_addr_i;
      e_we    = exp_d ? we : 1'b0;
      e_be    = exp_d ? dmem_be_i : 8'hFF;
      e_wdata = exp_d ? dmem_wdata_i : 64'd0;
      req_and_grant(ir, dr, we, gd);
      checks++;
      if (o_idle_mreq !== 0 || o_mreq_cycles !== gd + 1) begin
        errors++; $display("FAIL rand%0d_addr_phase: got idle_req %0d cycles %0d expected 0 %0d", t, o_idle_mreq, o_mreq_cycles, gd + 1);
      end
      checks++;
      if (o_igrant !== int'(!exp_d) || o_dgrant !== int'(exp_d)) begin
        errors++; $display("FAIL rand%0d_winner: got igrant %0d dgrant %0d expected data_wins=%0d", t, o_igrant, o_dgrant, exp_d);
      end
      checks++;
      if (o_addr !== e_addr || o_we !== e_we || o_be !== e_be || o_wdata !== e_wdata) begin
        errors++; $display("FAIL rand%0d_fields: got %h/%b/%h/%h expected %h/%b/%h/%h", t, o_addr, o_we, o_be, o_wdata, e_addr, e_we, e_be, e_wdata);
      end
      ref_last_d = exp_d;
      exp_i_beats = exp_d ? 0 : int'(IBURST);
      exp_d_beats = (exp_d && !we) ? 1 : 0;
      if (exp_i_beats + exp_d_beats > 0) begin
        respond(exp_i_beats + exp_d_beats, 4);
        checks++;
        if (o_ircnt !== exp_i_beats || o_drcnt !== exp_d_beats || o_to !== 0 || o_spur !== 0 || data_queue_bad()) begin
          errors++; $display("FAIL rand%0d_resp: got i %0d d %0d to %0d spur %0d expected i %0d d %0d clean", t, o_ircnt, o_drcnt, o_to, o_spur, exp_i_beats, exp_d_beats);
        end
      end
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0) begin
        errors++; $display("FAIL rand%0d_busy_after: got %b expected 0", t, busy_o);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    rand_fields();
    test_reset();
    test_ifetch();
    test_arbitration();
    test_write();
    test_timeout();
    test_spurious();
    test_reset_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/obi_mem_arbiter.md
OBI_MEM_ARBITER -- requirements
Module: obi_mem_arbiter

Interface
REQ-001 SHALL have parameter IBURST_LEN, default 8: rvalid beats returned per instruction request (range 1-255).
REQ-002 SHALL have parameter WRITE_RSP, default 0: 1 = writes complete on mem_rvalid_i; 0 = writes complete on mem_gnt_i.
REQ-003 SHALL have parameter TIMEOUT, default 1024: maximum cycles between response beats (range 1-65535).
REQ-004 SHALL use one clock, clk_i; reset is rst_i, synchronous, active-high.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 imem_req_i  in  1  instruction burst-read request.
REQ-008 imem_addr_i  in  64  burst start address.
REQ-009 imem_gnt_o  out  1  instruction request accepted.
REQ-010 imem_rvalid_o  out  1  instruction beat valid.
REQ-011 imem_rdata_o  out  64  instruction beat data.
REQ-012 dmem_req_i / dmem_we_i  in  1 each  data request / write enable.
REQ-013 dmem_be_i  in  8  byte enables.
REQ-014 dmem_addr_i / dmem_wdata_i  in  64 each  data address / write data.
REQ-015 dmem_gnt_o / dmem_rvalid_o  out  1 each  data grant / read-response valid.
REQ-016 dmem_rdata_o  out  64  data read data.
REQ-017 mem_req_o / mem_we_o  out  1 each  downstream request / write enable.
REQ-018 mem_be_o  out  8; mem_addr_o / mem_wdata_o  out  64 each  downstream request fields.
REQ-019 mem_gnt_i / mem_rvalid_i  in  1 each; mem_rdata_i  in  64  downstream grant and response.
REQ-020 busy_o  out  1  state is not IDLE.
REQ-021 timeout_o / spurious_o  out  1 each  one-cycle error pulses.

Function
REQ-022 SHALL implement FSM states IDLE, ADDR, IRESP, DRESP; at most one outstanding downstream transaction.
REQ-023 IDLE: if any upstream req, latch owner and go to ADDR next cycle; tie-break is round-robin against last_owner (last owner loses).
REQ-024 ADDR: mem_req_o=1; fields driven combinationally from owner inputs; instruction owner drives we=0, be=8'hFF, wdata=0.
REQ-025 ADDR with mem_gnt_i=1: owner gnt_o=1 in the same cycle; last_owner<=owner; next state IRESP (instr), DRESP (data read, or write with WRITE_RSP=1), IDLE (write with WRITE_RSP=0).
REQ-026 ADDR with mem_gnt_i=0: hold ADDR, request and fields unchanged; no timeout in ADDR.
REQ-027 imem_gnt_o and dmem_gnt_o SHALL be 0 outside ADDR and for the non-owner.
REQ-028 IRESP: each mem_rvalid_i drives imem_rvalid_o=1 combinationally; 8-bit beat counter increments; beat IBURST_LEN returns FSM to IDLE.
REQ-029 DRESP: first mem_rvalid_i goes to IDLE; dmem_rvalid_o=1 only for reads (write completion is not forwarded).
REQ-030 imem_rdata_o and dmem_rdata_o SHALL equal mem_rdata_i at all times.
REQ-031 16-bit wait counter: cleared on entry to IRESP/DRESP and on each rvalid, otherwise increments.
REQ-032 When the wait counter reaches TIMEOUT-1 without rvalid: timeout_o=1 for one cycle, return to IDLE, drop the transaction.
REQ-033 mem_rvalid_i in IDLE or ADDR: spurious_o=1 for one cycle; not forwarded; state unchanged.
REQ-034 Last response beat and new upstream requests in the same cycle: go to IDLE first, arbitrate next cycle (1 idle cycle between transactions).
REQ-035 Latency: upstream req at cycle N with mem_gnt_i tied to mem_req_o gives mem_req_o and owner gnt_o at N+1.

Reset
REQ-036 On rst_i=1 at a clock edge: state=IDLE; counters=0; last_owner=DATA (instruction wins first tie).
REQ-037 During and after reset: all outputs 0 except rdata passthrough; any in-flight transaction is abandoned.
REQ-038 Reset asserted mid-burst: beats arriving after reset raise spurious_o and are not forwarded.

Verification
REQ-039 Single imem req addr 0x100, memory returns 8 beats: one mem_req_o cycle, imem_gnt_o once, 8 imem_rvalid_o, busy_o low after beat 8.
REQ-040 imem and dmem req together out of reset: instruction served first, then data; next simultaneous pair serves data first.
REQ-041 dmem write be=0x0F addr 0x10000 with WRITE_RSP=0: mem_we_o=1, mem_be_o=0x0F, dmem_gnt_o pulse, no dmem_rvalid_o, FSM in IDLE next cycle.
REQ-042 dmem read, memory never responds, TIMEOUT=16: timeout_o pulses 16 cycles after grant, then busy_o=0.
REQ-043 mem_rvalid_i injected in IDLE: spurious_o=1 for one cycle; imem_rvalid_o=0 and dmem_rvalid_o=0.
REQ-044 rst_i asserted after beat 3 of a burst: busy_o=0 next cycle; a new dmem read then completes normally.
